// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: requester rectangle bus plus the shared pixel plot port.
interface vga_plot_arbiter_if;
  logic [3:0] req;
  logic [31:0] rect_x, rect_y, rect_w_m1, rect_h_m1;
  logic [11:0] rect_colour;
  logic [3:0] grant, done;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic plot, busy;
  modport master(output req, rect_x, rect_y, rect_w_m1, rect_h_m1, rect_colour,
                 input grant, done, x, y, colour, plot, busy);
  modport slave(input req, rect_x, rect_y, rect_w_m1, rect_h_m1, rect_colour,
                output grant, done, x, y, colour, plot, busy);
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin rectangle rasteriser for four requesters; PLOT_CLIP_EN gates off-screen plots.
module vga_plot_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic clk,
  input logic reset,
  vga_plot_arbiter_if.slave bus
);
`ifdef PLOT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t st;
  logic [1:0] g, last, pick;
  logic [7:0] x0, y0, w, h, cx, cy, ncx, ncy, bx, by, ax, ay;
  logic [8:0] sx, sy;
  logic any, wrap, fin, vis;
  always_comb begin
    any = |bus.req;
    pick = last;
    for (int i = 3; i >= 0; i--)
      if (bus.req[last + 2'(i) + 2'd1]) pick = last + 2'(i) + 2'd1;
    wrap = cx == w;
    fin = wrap && cy == h;
    ncx = wrap ? 8'd0 : cx + 8'd1;
    ncy = wrap ? cy + 8'd1 : cy;
    // in IDLE the pixel being registered is the new rectangle's origin
    bx = st == IDLE ? bus.rect_x[8*pick +: 8] : x0;
    by = st == IDLE ? bus.rect_y[8*pick +: 8] : y0;
    ax = st == IDLE ? 8'd0 : ncx;
    ay = st == IDLE ? 8'd0 : ncy;
    sx = {1'b0, bx} + {1'b0, ax};
    sy = {1'b0, by} + {1'b0, ay};
    vis = !CLIP || (sx < 9'(SCREEN_W) && sy < 9'(SCREEN_H));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      g <= 2'd0;
      last <= 2'd3;
      x0 <= 8'd0;
      y0 <= 8'd0;
      w <= 8'd0;
      h <= 8'd0;
      cx <= 8'd0;
      cy <= 8'd0;
      bus.grant <= 4'd0;
      bus.done <= 4'd0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
      bus.x <= 8'd0;
      bus.y <= 8'd0;
      bus.colour <= 3'd0;
    end else
      case (st)
        IDLE: if (any) begin
          st <= DRAW;
          g <= pick;
          x0 <= bx;
          y0 <= by;
          w <= bus.rect_w_m1[8*pick +: 8];
          h <= bus.rect_h_m1[8*pick +: 8];
          cx <= 8'd0;
          cy <= 8'd0;
          bus.grant <= 4'd1 << pick;
          bus.busy <= 1'b1;
          bus.plot <= vis;
          bus.x <= sx[7:0];
          bus.y <= sy[7:0];
          bus.colour <= bus.rect_colour[3*pick +: 3];
        end
        DRAW: if (fin) begin
          st <= DONE;
          bus.plot <= 1'b0;
          bus.done <= 4'd1 << g;
        end else begin
          cx <= ncx;
          cy <= ncy;
          bus.plot <= vis;
          bus.x <= sx[7:0];
          bus.y <= sy[7:0];
        end
        DONE: begin
          st <= IDLE;
          last <= g;
          bus.done <= 4'd0;
          bus.grant <= 4'd0;
          bus.busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed rectangle sweeps checked pixel by pixel at the falling clock edge.
module tb_vga_plot_arbiter;
`ifdef PLOT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  vga_plot_arbiter_if bus();
  vga_plot_arbiter dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set(input int k, input int xx, input int yy, input int ww, input int hh, input int cc);
    bus.rect_x[8*k +: 8] = 8'(xx);
    bus.rect_y[8*k +: 8] = 8'(yy);
    bus.rect_w_m1[8*k +: 8] = 8'(ww);
    bus.rect_h_m1[8*k +: 8] = 8'(hh);
    bus.rect_colour[3*k +: 3] = 3'(cc);
  endtask
  task automatic serve(input int k, input int xx, input int yy, input int ww, input int hh, input int cc);
    logic [3:0] g1;
    logic vis;
    int ex, ey;
    g1 = 4'(1 << k);
    for (int j = 0; j <= hh; j++)
      for (int i = 0; i <= ww; i++) begin
        @(negedge clk);
        ex = xx + i;
        ey = yy + j;
        vis = !CLIP || (ex < 160 && ey < 120);
        chk("pixel", {4'd0, bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour},
            {4'd0, g1, 4'd0, vis, 1'b1, 8'(ex), 8'(ey), 3'(cc)});
      end
    @(negedge clk);
    chk("done", {22'd0, bus.grant, bus.done, bus.plot, bus.busy}, {22'd0, g1, g1, 1'b0, 1'b1});
    bus.req[k] = 1'b0;
    @(negedge clk);
    chk("idle", {22'd0, bus.grant, bus.done, bus.plot, bus.busy}, 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    bus.req = 4'd0;
    bus.rect_x = '0;
    bus.rect_y = '0;
    bus.rect_w_m1 = '0;
    bus.rect_h_m1 = '0;
    bus.rect_colour = '0;
    #12;
    chk("reset", {4'd0, bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set(0, 72, 110, 15, 1, 7);
    bus.req[0] = 1'b1;
    serve(0, 72, 110, 15, 1, 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set(i, 10 * i, 5 * i, 0, 0, i + 1);
    bus.req = 4'hF;
    for (int i = 0; i < 4; i++) serve(i, 10 * i, 5 * i, 0, 0, i + 1);
    bus.req[0] = 1'b1;
    bus.req[2] = 1'b1;
    serve(0, 0, 0, 0, 0, 1);
    bus.req[0] = 1'b1;
    serve(2, 20, 10, 0, 0, 3);
    bus.req[2] = 1'b1;
    serve(0, 0, 0, 0, 0, 1);
    bus.req[0] = 1'b1;
    bus.req[1] = 1'b1;
    serve(1, 10, 5, 0, 0, 2);
    serve(2, 20, 10, 0, 0, 3);
    serve(0, 0, 0, 0, 0, 1);
    set(0, 0, 0, 159, 119, 0);
    bus.req[0] = 1'b1;
    serve(0, 0, 0, 159, 119, 0);
    set(0, 10, 20, 15, 1, 5);
    bus.req[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("pixel10", {4'd0, bus.grant, bus.done, bus.plot, bus.busy, bus.x, bus.y, bus.colour},
        {4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 8'd19, 8'd20, 3'd5});
    #2 reset = 1'b1;
    bus.req = 4'd0;
    #1 chk("async_rst", {22'd0, bus.grant, bus.done, bus.plot, bus.busy}, 32'd0);
    @(negedge clk);
    chk("rst_nodone", {22'd0, bus.grant, bus.done, bus.plot, bus.busy}, 32'd0);
    reset = 1'b0;
    bus.req[0] = 1'b1;
    serve(0, 10, 20, 15, 1, 5);
    set(0, 150, 5, 15, 0, 2);
    bus.req[0] = 1'b1;
    serve(0, 150, 5, 15, 0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
